// File: rtl/row_router_hs.sv
// Per-row input router: queues element addresses, matches them against
// broadcast scratchpad words and emits hits in request order.
module row_router_hs #(
  parameter int SPAD_DATA_WIDTH = 64,
  parameter int DATA_WIDTH      = 8,
  parameter int ADDR_WIDTH      = 8,
  parameter int ADDR_LENGTH     = 9,
  parameter int AQ_DEPTH        = 16,
  parameter int PEEK_WIDTH      = 8,
  parameter int OUT_DEPTH       = 32,
  localparam int WORDS   = SPAD_DATA_WIDTH / DATA_WIDTH,
  localparam int OFF_W   = $clog2(WORDS),
  localparam int WADDR_W = ADDR_WIDTH - OFF_W,
  localparam int CNT_W   = $clog2(ADDR_LENGTH + 1),
  localparam int AQ_CW   = $clog2(AQ_DEPTH + 1)
) (
  input  logic                                   i_clk,
  input  logic                                   i_nrst,
  input  logic                                   i_clear,
  input  logic                                   i_en,
  input  logic [ADDR_LENGTH-1:0][ADDR_WIDTH-1:0] i_ag_addr,
  input  logic [ADDR_LENGTH-1:0]                 i_ag_pad,
  input  logic [CNT_W-1:0]                       i_ag_count,
  input  logic                                   i_ag_valid,
  output logic                                   o_ag_ready,
  input  logic [SPAD_DATA_WIDTH-1:0]             i_data,
  input  logic [WADDR_W-1:0]                     i_addr,
  input  logic                                   i_data_valid,
  output logic [DATA_WIDTH-1:0]                  o_data,
  output logic                                   o_valid,
  input  logic                                   i_ready,
  output logic [AQ_CW-1:0]                       o_aq_count,
  output logic                                   o_stall,
  output logic                                   o_done
);

  localparam int AQ_AW  = $clog2(AQ_DEPTH);
  localparam int OUT_AW = $clog2(OUT_DEPTH);
  localparam int OUT_CW = $clog2(OUT_DEPTH + 1);
  localparam int PK_CW  = $clog2(PEEK_WIDTH + 1);

  logic [ADDR_WIDTH-1:0] aq_addr [AQ_DEPTH];
  logic [AQ_DEPTH-1:0]   aq_pad;
  logic [AQ_AW-1:0]      head, tail;
  logic [AQ_CW-1:0]      count;

  logic [DATA_WIDTH-1:0] ob [OUT_DEPTH];
  logic [OUT_AW-1:0]     ohead, otail;
  logic [OUT_CW-1:0]     ocount;

  logic [PEEK_WIDTH-1:0]                 hit;
  logic [PEEK_WIDTH-1:0][DATA_WIDTH-1:0] pdata;
  logic [PK_CW-1:0]                      lead, n;
  logic [OUT_CW-1:0]                     space;
  logic [AQ_CW-1:0]                      nadd;
  logic                                  run, ag_fire, pop;

  assign o_ag_ready = (AQ_CW'(AQ_DEPTH) - count) >= AQ_CW'(ADDR_LENGTH);
  assign ag_fire    = i_ag_valid & o_ag_ready;
  assign nadd       = ag_fire ? AQ_CW'(i_ag_count) : '0;

  always_comb begin
    hit   = '0;
    pdata = '0;
    for (int k = 0; k < PEEK_WIDTH; k++) begin
      if (AQ_CW'(k) < count) begin
        if (aq_pad[head + AQ_AW'(k)]) begin
          hit[k] = 1'b1;
        end else if (i_data_valid &&
            aq_addr[head + AQ_AW'(k)][ADDR_WIDTH-1:OFF_W] == i_addr) begin
          hit[k]   = 1'b1;
          pdata[k] = i_data[int'(aq_addr[head + AQ_AW'(k)][OFF_W-1:0])
                            * DATA_WIDTH +: DATA_WIDTH];
        end
      end
    end
  end

  // Only the unbroken run of hits from the head may leave, to keep order
  always_comb begin
    lead = '0;
    run  = 1'b1;
    for (int k = 0; k < PEEK_WIDTH; k++) begin
      if (run && hit[k]) lead = PK_CW'(k + 1);
      else run = 1'b0;
    end
  end

  assign space   = OUT_CW'(OUT_DEPTH) - ocount;
  assign n       = !i_en ? '0 :
                   (OUT_CW'(lead) <= space) ? lead : PK_CW'(space);
  assign o_stall = i_en & (lead > n);

  assign o_valid    = ocount != '0;
  assign pop        = o_valid & i_ready;
  assign o_data     = o_valid ? ob[ohead] : '0;
  assign o_aq_count = count;
  assign o_done     = (count == '0) & (ocount == '0);

  always_ff @(posedge i_clk or negedge i_nrst) begin
    if (!i_nrst) begin
      head   <= '0;
      tail   <= '0;
      count  <= '0;
      ohead  <= '0;
      otail  <= '0;
      ocount <= '0;
    end else if (i_clear) begin
      head   <= '0;
      tail   <= '0;
      count  <= '0;
      ohead  <= '0;
      otail  <= '0;
      ocount <= '0;
    end else begin
      head   <= head + AQ_AW'(n);
      tail   <= tail + AQ_AW'(nadd);
      count  <= count + nadd - AQ_CW'(n);
      ohead  <= ohead + OUT_AW'(pop);
      otail  <= otail + OUT_AW'(n);
      ocount <= ocount + OUT_CW'(n) - OUT_CW'(pop);
    end
  end

  // Storage needs no reset; pointers and counts define validity
  always_ff @(posedge i_clk) begin
    if (ag_fire && !i_clear) begin
      for (int j = 0; j < ADDR_LENGTH; j++) begin
        if (CNT_W'(j) < i_ag_count) begin
          aq_addr[tail + AQ_AW'(j)] <= i_ag_addr[j];
          aq_pad[tail + AQ_AW'(j)]  <= i_ag_pad[j];
        end
      end
    end
    if (!i_clear) begin
      for (int k = 0; k < PEEK_WIDTH; k++) begin
        if (PK_CW'(k) < n) ob[otail + OUT_AW'(k)] <= pdata[k];
      end
    end
  end

endmodule

// File: tb/tb_row_router_hs.sv
// Directed self-checking bench for row_router_hs.
// Inputs change 1ns after the rising edge; outputs checked before the next.
module tb_row_router_hs;

  logic            clk = 1'b0;
  logic            nrst = 1'b0;
  logic            clear = 1'b0;
  logic            en = 1'b0;
  logic [8:0][7:0] ag_addr = '0;
  logic [8:0]      ag_pad = '0;
  logic [3:0]      ag_count = '0;
  logic            ag_valid = 1'b0;
  logic            ag_ready;
  logic [63:0]     data = '0;
  logic [4:0]      addr = '0;
  logic            data_valid = 1'b0;
  logic [7:0]      dout;
  logic            valid;
  logic            ready = 1'b0;
  logic [4:0]      aq_count;
  logic            stall;
  logic            done;

  int checks = 0;
  int failures = 0;

  row_router_hs dut (
    .i_clk        (clk),
    .i_nrst       (nrst),
    .i_clear      (clear),
    .i_en         (en),
    .i_ag_addr    (ag_addr),
    .i_ag_pad     (ag_pad),
    .i_ag_count   (ag_count),
    .i_ag_valid   (ag_valid),
    .o_ag_ready   (ag_ready),
    .i_data       (data),
    .i_addr       (addr),
    .i_data_valid (data_valid),
    .o_data       (dout),
    .o_valid      (valid),
    .i_ready      (ready),
    .o_aq_count   (aq_count),
    .o_stall      (stall),
    .o_done       (done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic seq(input logic [7:0] base, input int cnt);
    for (int j = 0; j < 9; j++) ag_addr[j] = base + 8'(j);
    ag_pad   = '0;
    ag_count = 4'(cnt);
    ag_valid = 1'b1;
  endtask

  task automatic pads(input int cnt);
    ag_addr  = '0;
    ag_pad   = '1;
    ag_count = 4'(cnt);
    ag_valid = 1'b1;
  endtask

  task automatic word(input logic [4:0] a, input logic [63:0] d);
    addr       = a;
    data       = d;
    data_valid = 1'b1;
    en         = 1'b1;
  endtask

  task automatic noword();
    data_valid = 1'b0;
    en         = 1'b0;
  endtask

  initial begin
    // reset and idle
    #2;
    check("rst_ready", ag_ready, 1);
    check("rst_done", done, 1);
    check("rst_valid", valid, 0);
    check("rst_aqcnt", aq_count, 0);
    check("rst_data", dout, 0);
    check("rst_stall", stall, 0);
    nrst = 1'b1;
    tick();
    tick();
    check("idle_done", done, 1);

    // full 8-element burst from one word
    seq(8'h10, 8);
    tick();
    word(5'h02, 64'h0706050403020100);
    seq(8'h40, 8);
    #1;
    check("b8_aqcnt", aq_count, 8);
    check("b8_notready", ag_ready, 0);
    check("b8_stall", stall, 0);
    tick();
    ag_valid = 1'b0;
    noword();
    check("b8_aqcnt_after", aq_count, 0);
    check("b8_valid", valid, 1);
    ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      check("b8_pop", dout, 64'(i));
      tick();
    end
    ready = 1'b0;
    check("b8_empty", valid, 0);
    check("b8_done", done, 1);

    // pad entry and a partial match
    seq(8'h10, 3);
    ag_pad[1]  = 1'b1;
    ag_addr[2] = 8'h20;
    tick();
    ag_valid = 1'b0;
    word(5'h02, 64'h00000000000000AA);
    #1;
    check("pad_stall", stall, 0);
    tick();
    noword();
    check("pad_aqcnt", aq_count, 1);
    ready = 1'b1;
    check("pad_d0", dout, 8'hAA);
    tick();
    check("pad_d1", dout, 8'h00);
    check("pad_v1", valid, 1);
    tick();
    ready = 1'b0;
    check("pad_empty", valid, 0);
    word(5'h04, 64'h0000000000000055);
    tick();
    noword();
    check("pad_aq0", aq_count, 0);
    check("pad_d2", dout, 8'h55);
    ready = 1'b1;
    tick();
    ready = 1'b0;
    check("pad_done", done, 1);

    // head miss blocks a later hit
    seq(8'h20, 2);
    ag_addr[1] = 8'h10;
    tick();
    ag_valid = 1'b0;
    word(5'h02, 64'h1111111111111111);
    tick();
    noword();
    check("ord_aqcnt", aq_count, 2);
    check("ord_valid", valid, 0);
    check("ord_done", done, 0);
    clear = 1'b1;
    tick();
    clear = 1'b0;
    check("ord_clr", aq_count, 0);

    // backpressure: fill output FIFO to 30
    for (int r = 0; r < 4; r++) begin
      pads(r < 3 ? 8 : 6);
      tick();
      ag_valid = 1'b0;
      en = 1'b1;
      tick();
      en = 1'b0;
    end
    check("bp_aq0", aq_count, 0);
    check("bp_valid", valid, 1);
    seq(8'h10, 8);
    tick();
    ag_valid = 1'b0;
    word(5'h02, 64'h0706050403020100);
    #1;
    check("bp_stall", stall, 1);
    tick();
    check("bp_aq6", aq_count, 6);
    check("bp_stall_full", stall, 1);
    noword();
    ready = 1'b1;
    for (int i = 0; i < 32; i++) begin
      check("bp_drain", dout, i < 30 ? 64'h0 : 64'(i - 30));
      tick();
    end
    ready = 1'b0;
    check("bp_empty", valid, 0);
    word(5'h02, 64'h0706050403020100);
    #1;
    check("bp_stall2", stall, 0);
    tick();
    noword();
    check("bp_aq_end", aq_count, 0);
    ready = 1'b1;
    for (int i = 2; i < 8; i++) begin
      check("bp_rest", dout, 64'(i));
      tick();
    end
    ready = 1'b0;
    check("bp_done", done, 1);

    // async reset mid-stream
    pads(3);
    tick();
    ag_valid = 1'b0;
    en = 1'b1;
    tick();
    en = 1'b0;
    seq(8'h30, 2);
    tick();
    ag_valid = 1'b0;
    check("mr_aq2", aq_count, 2);
    nrst = 1'b0;
    #2;
    check("mr_valid", valid, 0);
    check("mr_aq", aq_count, 0);
    check("mr_done", done, 1);
    check("mr_ready", ag_ready, 1);
    nrst = 1'b1;
    tick();

    // synchronous clear mid-stream, overriding a write
    pads(3);
    tick();
    ag_valid = 1'b0;
    en = 1'b1;
    tick();
    en = 1'b0;
    seq(8'h30, 2);
    tick();
    clear = 1'b1;
    #1;
    check("clr_before", valid, 1);
    tick();
    clear = 1'b0;
    ag_valid = 1'b0;
    check("clr_valid", valid, 0);
    check("clr_aq", aq_count, 0);
    check("clr_done", done, 1);
    check("clr_ready", ag_ready, 1);
    check("clr_data", dout, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
